// File: rtl/zf_pilot_seq_pkg.sv
// zf_pilot_seq_pkg: shared FSM state, default geometry and IQ sample type for the pilot sequencer.
package zf_pilot_seq_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESYNC} seq_state_e;
    localparam int DEF_BEATS_PER_SYM = 256;
    localparam int DEF_PILOT_FIRST   = 27;
    localparam int DEF_PILOT_LAST    = 227;
    typedef logic signed [15:0] iq_sample_t;
endpackage

// File: rtl/zf_axis_reg_slice.sv
// zf_axis_reg_slice: one-entry AXI-stream register slice, latency 1, full throughput.
module zf_axis_reg_slice #(
    parameter int W = 128
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_valid_i,
    input  logic [W-1:0] s_data_i,
    input  logic         s_last_i,
    output logic         s_ready_o,
    output logic         m_valid_o,
    output logic [W-1:0] m_data_o,
    output logic         m_last_o,
    input  logic         m_ready_i
);
    logic         valid_q, last_q;
    logic [W-1:0] data_q;
    assign s_ready_o = m_ready_i | ~valid_q;
    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign m_last_o  = last_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (s_ready_o) begin
            valid_q <= s_valid_i;
            if (s_valid_i) begin
                data_q <= s_data_i;
                last_q <= s_last_i;
            end
        end
    end
endmodule

// File: rtl/zf_pilot_sequencer.sv
// zf_pilot_sequencer: OFDM symbol framing, tlast realignment and pilot extraction on a 128-bit stream.
// Define ZF_PILOT_SEQ_STATS_EN to enable the sym_count/err_count statistics counters.
module zf_pilot_sequencer
    import zf_pilot_seq_pkg::*;
#(
    parameter int BEATS_PER_SYM = DEF_BEATS_PER_SYM,
    parameter int PILOT_FIRST   = DEF_PILOT_FIRST,
    parameter int PILOT_LAST    = DEF_PILOT_LAST
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         enable,
    input  logic         bypass,
    input  logic         clr_err,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    output logic         s_axis_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready,
    output logic [7:0]   pilot_rom_addr,
    output logic [31:0]  pilot_rx_tdata,
    output logic         pilot_rx_tvalid,
    output logic         sym_start,
    output logic         sym_done,
    output logic         err_tlast,
    output logic [15:0]  sym_count,
    output logic [7:0]   err_count
);
    localparam int CW = $clog2(BEATS_PER_SYM);
    localparam logic [CW-1:0] LAST = CW'(BEATS_PER_SYM - 1);
    localparam logic [CW-1:0] PF   = CW'(PILOT_FIRST);
    localparam logic [CW-1:0] PL   = CW'(PILOT_LAST);
    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             slice_ready, acc, run_acc, at_last, err, done_ev, pilot_hit;
    logic             sym_start_q, sym_done_q, err_q, addr_v_q, rx_v_q;
    logic [7:0]       addr_q;
    iq_sample_t [1:0] pil_q, rx_q;
    assign s_axis_tready = state_q == ST_RUN ? slice_ready : state_q == ST_RESYNC;
    assign acc       = s_axis_tvalid & s_axis_tready;
    assign run_acc   = acc & (state_q == ST_RUN);
    assign at_last   = cnt_q == LAST;
    // A misaligned tlast in either direction is an error; the offending beat still closes the output symbol.
    assign err       = run_acc & (s_axis_tlast ^ at_last);
    assign done_ev   = run_acc & at_last & s_axis_tlast;
    assign pilot_hit = run_acc & ~bypass & (cnt_q >= PF) & (cnt_q <= PL);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (enable) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: if (run_acc) begin
                cnt_d   = (at_last || err) ? '0 : cnt_q + 1'b1;
                state_d = err ? ST_RESYNC : (at_last && !enable) ? ST_IDLE : ST_RUN;
            end
            ST_RESYNC: if (acc && s_axis_tlast) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sym_start_q <= 1'b0;
            sym_done_q  <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            addr_v_q    <= 1'b0;
            pil_q       <= '0;
            rx_v_q      <= 1'b0;
            rx_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sym_start_q <= run_acc & (cnt_q == '0);
            sym_done_q  <= done_ev;
            err_q       <= err | (err_q & ~clr_err);
            addr_v_q    <= pilot_hit;
            rx_v_q      <= addr_v_q;
            if (pilot_hit) begin
                addr_q <= 8'(cnt_q - PF);
                pil_q  <= s_axis_tdata[127:96];
            end
            // Delay the rx pilot one more cycle so it meets the ROM's registered read data.
            if (addr_v_q) rx_q <= pil_q;
        end
    end
    zf_axis_reg_slice #(.W(128)) u_slice (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .s_valid_i (run_acc),
        .s_data_i  (s_axis_tdata),
        .s_last_i  (at_last | s_axis_tlast),
        .s_ready_o (slice_ready),
        .m_valid_o (m_axis_tvalid),
        .m_data_o  (m_axis_tdata),
        .m_last_o  (m_axis_tlast),
        .m_ready_i (m_axis_tready)
    );
    assign pilot_rom_addr  = addr_q;
    assign pilot_rx_tdata  = rx_q;
    assign pilot_rx_tvalid = rx_v_q;
    assign sym_start       = sym_start_q;
    assign sym_done        = sym_done_q;
    assign err_tlast       = err_q;
`ifdef ZF_PILOT_SEQ_STATS_EN
    logic [15:0] sym_cnt_q;
    logic [7:0]  err_cnt_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (done_ev) sym_cnt_q <= sym_cnt_q + 16'd1;
            if (err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
    assign sym_count = sym_cnt_q;
    assign err_count = err_cnt_q;
`else
    assign sym_count = '0;
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_zf_pilot_sequencer.sv
// tb_zf_pilot_sequencer: scoreboard bench; stimulus pushes expected beats/pilots, a negedge monitor pops and compares.
module tb_zf_pilot_sequencer;
`ifdef ZF_PILOT_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic         aclk, aresetn, enable, bypass, clr_err;
    logic [127:0] s_axis_tdata, m_axis_tdata;
    logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [7:0]   pilot_rom_addr, err_count;
    logic [31:0]  pilot_rx_tdata;
    logic         pilot_rx_tvalid, sym_start, sym_done, err_tlast;
    logic [15:0]  sym_count;
    zf_pilot_sequencer dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .bypass(bypass), .clr_err(clr_err),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .pilot_rom_addr(pilot_rom_addr),
        .pilot_rx_tdata(pilot_rx_tdata), .pilot_rx_tvalid(pilot_rx_tvalid), .sym_start(sym_start),
        .sym_done(sym_done), .err_tlast(err_tlast), .sym_count(sym_count), .err_count(err_count)
    );
    logic [198:0] outs;
    assign outs = {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, pilot_rom_addr, pilot_rx_tdata,
                   pilot_rx_tvalid, sym_start, sym_done, err_tlast, sym_count, err_count};
    int checks = 0, errors = 0;
    int exp_start = 0, exp_done = 0, exp_sym = 0, exp_err = 0, n_start = 0, n_done = 0;
    int seq = 0;
    bit bp_en = 0;
    logic [128:0] exp_m[$];
    logic [39:0]  exp_p[$];
    logic [7:0]   addr_hist = '0;
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) begin
        #2;
        m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_m.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_unexpected actual=%0h required=none", m_axis_tdata);
                end else chk("m_beat", {m_axis_tlast, m_axis_tdata}, exp_m.pop_front());
            end
            if (pilot_rx_tvalid) begin
                if (exp_p.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pilot_unexpected actual=%0h required=none", pilot_rx_tdata);
                end else begin
                    logic [39:0] e;
                    e = exp_p.pop_front();
                    chk("pilot_data", pilot_rx_tdata, e[31:0]);
                    chk("pilot_addr", addr_hist, e[39:32]);
                end
            end
            if (sym_start) n_start++;
            if (sym_done) n_done++;
        end
        addr_hist = pilot_rom_addr;
    end
    function automatic logic [127:0] mk(input int s);
        return {16'(s), 16'(~s), 32'(s * 3), 32'(s), 32'(s ^ 32'h5a5a5a5a)};
    endfunction
    task automatic gap(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask
    task automatic send(input logic [127:0] d, input logic l);
        int t = 0;
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 2000) chk("accept_timeout", 0, 1);
        @(posedge aclk);
        #1;
    endtask
    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("async_reset_outputs", outs, '0);
        exp_m.delete(); exp_p.delete();
        exp_sym = 0; exp_err = 0;
        gap(3);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("post_release_outputs", outs, '0);
    endtask
    task automatic sym(input int n, input bit tl_end, input bit byp, input int en_drop_at, input int rst_at);
        logic [127:0] d;
        bypass = byp;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                do_reset();
                bypass = 1'b0;
                return;
            end
            if (i == en_drop_at) enable = 1'b0;
            d = mk(seq++);
            exp_m.push_back({i == n - 1, d});
            if (!byp && i >= 27 && i <= 227) exp_p.push_back({8'(i - 27), d[127:96]});
            if (i == 0) exp_start++;
            send(d, i == n - 1 ? tl_end : 1'b0);
        end
        s_axis_tvalid = 1'b0;
        bypass = 1'b0;
        if (n == 256 && tl_end) begin exp_done++; exp_sym++; end
        else exp_err++;
    endtask
    task automatic drop(input int n);
        for (int i = 0; i < n; i++) send(mk(seq++), i == n - 1);
        s_axis_tvalid = 1'b0;
    endtask
    initial begin
        aresetn = 1'b0; enable = 1'b0; bypass = 1'b0; clr_err = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        gap(3);
        chk("reset_outputs", outs, '0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("reset_hold_outputs", outs, '0);
        gap(1);
        chk("idle_tready", s_axis_tready, 0);
        enable = 1'b1;
        repeat (3) begin sym(256, 1, 0, -1, -1); gap(64); end
        chk("sym_count_3", sym_count, STATS ? exp_sym : 0);
        chk("err_tlast_clean", err_tlast, 0);
        clr_err = 1'b1;
        sym(101, 1, 0, -1, -1);
        chk("err_set_wins", err_tlast, 1);
        clr_err = 1'b0;
        drop(20);
        gap(8);
        sym(256, 1, 0, -1, -1);
        gap(8);
        chk("err_sticky", err_tlast, 1);
        sym(256, 0, 0, -1, -1);
        drop(5);
        gap(8);
        chk("err_count_2", err_count, STATS ? exp_err : 0);
        clr_err = 1'b1;
        gap(1);
        clr_err = 1'b0;
        chk("err_cleared", err_tlast, 0);
        bp_en = 1'b1;
        repeat (2) begin sym(256, 1, 0, -1, -1); gap(16); end
        bp_en = 1'b0;
        sym(256, 1, 1, -1, -1);
        gap(16);
        sym(256, 1, 0, 50, -1);
        gap(4);
        chk("enable_drop_idle_tready", s_axis_tready, 0);
        enable = 1'b1;
        gap(2);
        sym(256, 1, 0, -1, 130);
        sym(256, 1, 0, -1, -1);
        gap(20);
        chk("m_queue_drained", exp_m.size(), 0);
        chk("pilot_queue_drained", exp_p.size(), 0);
        chk("sym_start_pulses", n_start, exp_start);
        chk("sym_done_pulses", n_done, exp_done);
        chk("sym_count_final", sym_count, STATS ? exp_sym : 0);
        chk("err_count_final", err_count, STATS ? exp_err : 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zf_pilot_sequencer.md
ZF_PILOT_SEQUENCER -- requirements
Module: zf_pilot_sequencer

Interface
REQ-001 SHALL have parameter BEATS_PER_SYM, default 256, meaning 128-bit beats (4 samples each) per OFDM symbol.
REQ-002 SHALL have parameter PILOT_FIRST, default 27, meaning first beat index carrying a pilot.
REQ-003 SHALL have parameter PILOT_LAST, default 227, meaning last beat index carrying a pilot.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
 aclk  in  1  single clock, all logic rising-edge
 aresetn  in  1  asynchronous active-low reset
 enable  in  1  run symbol sequencing
 bypass  in  1  suppress pilot extraction, keep passthrough
 clr_err  in  1  clears err_tlast
 s_axis_tdata  in  128  {q3,i3,q2,i2,q1,i1,q0,i0}, 16-bit signed each
 s_axis_tvalid  in  1  input valid
 s_axis_tlast  in  1  last beat of symbol
 s_axis_tready  out  1  input ready
 m_axis_tdata  out  128  forwarded beat
 m_axis_tvalid  out  1  output valid
 m_axis_tlast  out  1  regenerated symbol end
 m_axis_tready  in  1  output ready
 pilot_rom_addr  out  8  tx-pilot ROM address (ROM read latency 1)
 pilot_rx_tdata  out  32  {q3,i3} of pilot beat
 pilot_rx_tvalid  out  1  pilot_rx_tdata valid; aligned with ROM data
 sym_start  out  1  one-cycle pulse, first beat of symbol accepted
 sym_done  out  1  one-cycle pulse, last beat of symbol accepted
 err_tlast  out  1  sticky tlast-misalignment flag
 sym_count  out  16  symbols completed (stats)
 err_count  out  8  misalignments seen, saturating (stats)

Function
REQ-005 SHALL implement FSM IDLE, RUN, RESYNC; accepted beat = s_axis_tvalid & s_axis_tready.
REQ-006 IDLE: s_axis_tready=0; -> RUN when enable=1, beat counter=0.
REQ-007 RUN: counter increments per accepted beat; beat at count 0 pulses sym_start next cycle.
REQ-008 RUN, count=BEATS_PER_SYM-1 with tlast=1: sym_done pulse, counter->0; -> IDLE if enable=0, else stay RUN.
REQ-009 RUN, tlast=1 at count<BEATS_PER_SYM-1, or tlast=0 at count=BEATS_PER_SYM-1: set err_tlast, -> RESYNC; offending beat forwarded with m_axis_tlast=1.
REQ-010 RESYNC: s_axis_tready=1, beats dropped (no m_axis, no pilots) until accepted tlast, then -> RUN, counter=0.
REQ-011 Passthrough SHALL be a one-entry register slice, latency 1; s_axis_tready in RUN = m_axis_tready | ~m_axis_tvalid; no beat lost or duplicated under backpressure.
REQ-012 m_axis_tlast SHALL equal (count==BEATS_PER_SYM-1), not the input tlast (except REQ-009).
REQ-013 Pilot beat (RUN, bypass=0, PILOT_FIRST<=count<=PILOT_LAST) accepted at cycle N: pilot_rom_addr=count-PILOT_FIRST registered at N+1; pilot_rx_tdata=s_axis_tdata[127:96], pilot_rx_tvalid=1 at N+2, one cycle.
REQ-014 pilot_rom_addr SHALL hold its last value when no pilot beat is accepted.
REQ-015 enable deasserting mid-symbol SHALL let the symbol complete before IDLE.
REQ-016 clr_err together with a new error SHALL leave err_tlast=1 (set wins).

Reset
REQ-017 aresetn=0 SHALL force asynchronously: state IDLE, counter 0, all outputs 0 (tdata buses 0), pending slice and pilot pipeline entries discarded.
REQ-018 Outputs SHALL remain 0 until first rising aclk after aresetn deasserts.

Configuration
REQ-019 With ZF_PILOT_SEQ_STATS_EN defined: sym_count increments (wraps) at each sym_done; err_count increments saturating at 255 per REQ-009 event; both cleared by reset only.
REQ-020 Without ZF_PILOT_SEQ_STATS_EN: sym_count and err_count SHALL be constant 0, no counter logic.

Structure
REQ-021 Package zf_pilot_seq_pkg SHALL hold the FSM state enum, default BEATS_PER_SYM/PILOT_FIRST/PILOT_LAST constants and the 16-bit IQ sample typedef.
REQ-022 The register slice SHALL be sub-module zf_axis_reg_slice.

Verification
REQ-023 3 symbols, 256 beats+64 idle, tlast at beat 255 -> 3 sym_start/sym_done pulses, 201 pilot_rx_tvalid per symbol, addr 0..200, sym_count=3.
REQ-024 tlast at beat 100 -> err_tlast=1, beats dropped until next tlast, next symbol clean, err_count=1.
REQ-025 m_axis_tready toggled 50% random -> output equals input sequence, m_axis_tlast every 256th beat.
REQ-026 bypass=1 for one symbol -> zero pilot_rx_tvalid, 256 beats forwarded.
REQ-027 aresetn low at beat 130 -> all outputs 0 same cycle; restart counts from beat 0.
REQ-028 enable dropped at beat 50 -> symbol completes to beat 255, then s_axis_tready=0.
